// File: rtl/fir_mac_sequencer_if.sv
// Stream-in / coefficient-write / stream-out bundle for the FIR MAC sequencer.
// The slave view belongs to the engine; the master view belongs to whatever
// drives samples and coefficients and drains the filtered output.
interface fir_mac_sequencer_if #(
  parameter int DIN_W  = 16,
  parameter int COEF_W = 12,
  parameter int DOUT_W = 16,
  parameter int AW     = 4
);
  logic [DIN_W-1:0]  s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic [DOUT_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  modport slave (
    input  s_tdata, s_tvalid, coef_we, coef_addr, coef_wdata, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, coef_we, coef_addr, coef_wdata, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one signed multiplier is walked over NTAPS taps per
// accepted sample. Holds the sample delay line, the coefficient file and the
// accumulator; result is rounded half-up, shifted and saturated to DOUT_W.
module fir_mac_sequencer #(
  parameter int NTAPS  = 16,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 12,
  parameter int ACC_W  = 32,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 11
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  fir_mac_sequencer_if.slave     bus,
  output logic                   coef_drop,
  output logic                   busy
);
  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DIN_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  // Rounding bias and output clamp limits, one bit wider than the accumulator
  // so the bias add can never wrap.
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic signed [DIN_W-1:0]  x_reg [NTAPS];
  logic signed [COEF_W-1:0] h_reg [NTAPS];
  logic [AW-1:0]            wr_ptr_reg;
  logic [AW-1:0]            tap_reg;
  logic [AW-1:0]            rd_idx;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    acc_rnd;
  logic signed [ACC_W:0]    acc_shf;
  logic signed [DOUT_W-1:0] sat_val;
  logic [DOUT_W-1:0]        m_tdata_reg;
  logic                     coef_drop_reg;
  logic                     sample_take;
  logic                     coef_take;
  logic                     coef_lost;

  assign sample_take = (state_reg == ST_IDLE) && bus.s_tvalid;
  assign coef_take   = (state_reg == ST_IDLE) && bus.coef_we;
  assign coef_lost   = (state_reg != ST_IDLE) && bus.coef_we;

  // Tap product, running sum, and the rounded/saturated view of that sum.
  always_comb begin
    rd_idx  = wr_ptr_reg - tap_reg;
    prod    = PROD_W'(x_reg[rd_idx]) * PROD_W'(h_reg[tap_reg]);
    acc_sum = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_rnd = {acc_sum[ACC_W-1], acc_sum} + RND;
    acc_shf = acc_rnd >>> SHIFT;
    if (acc_shf > OUT_MAX) begin
      sat_val = OUT_MAX[DOUT_W-1:0];
    end else if (acc_shf < OUT_MIN) begin
      sat_val = OUT_MIN[DOUT_W-1:0];
    end else begin
      sat_val = acc_shf[DOUT_W-1:0];
    end
  end

  // Delay line and coefficient file; both only change while IDLE.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_reg[i] <= '0;
        h_reg[i] <= '0;
      end
    end else begin
      if (sample_take) begin
        x_reg[wr_ptr_reg] <= bus.s_tdata;
      end
      if (coef_take) begin
        h_reg[bus.coef_addr] <= bus.coef_wdata;
      end
    end
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one sample in, NTAPS MAC cycles, hold result until taken.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (bus.s_tvalid) state_next = ST_MAC;
      ST_MAC:  if (tap_reg == LAST_TAP) state_next = ST_OUT;
      ST_OUT:  if (bus.m_tready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator, tap counter, write pointer, output register and drop flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr_reg    <= '0;
      tap_reg       <= '0;
      acc_reg       <= '0;
      m_tdata_reg   <= '0;
      coef_drop_reg <= 1'b0;
    end else begin
      if (coef_lost) begin
        coef_drop_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (bus.s_tvalid) begin
            acc_reg <= '0;
            tap_reg <= '0;
          end
        end
        ST_MAC: begin
          acc_reg <= acc_sum;
          tap_reg <= tap_reg + AW'(1);
          if (tap_reg == LAST_TAP) begin
            // Final tap: the result register loads from the completed sum so
            // OUT starts right after the last MAC cycle.
            wr_ptr_reg  <= wr_ptr_reg + AW'(1);
            m_tdata_reg <= sat_val;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.s_tready = (state_reg == ST_IDLE) && !ap_rst;
  assign bus.m_tvalid = (state_reg == ST_OUT);
  assign bus.m_tdata  = m_tdata_reg;
  assign busy         = (state_reg == ST_MAC) || (state_reg == ST_OUT);
  assign coef_drop    = coef_drop_reg;
endmodule
